// File: rtl/field_arith_defs.sv
// Shared GF(2^61-1) field definitions and arithmetic helpers.
`default_nettype none

package field_arith_defs;

    localparam int F_NBITS = 61;

    typedef logic [F_NBITS-1:0] fe_t;

    localparam fe_t F_Q       = 61'h1FFF_FFFF_FFFF_FFFF;
    // F_Q + 2 - 2^F_NBITS, so that ~x + F_Q_P2_MI == F_Q + 1 - x
    localparam fe_t F_Q_P2_MI = 61'd1;

    localparam logic [F_NBITS:0] F_Q_X = {1'b0, F_Q};

    // Single conditional subtract; valid for any input below 2*F_Q
    function automatic fe_t mod_fold(input logic [F_NBITS:0] s);
        logic [F_NBITS:0] r;
        r = (s >= F_Q_X) ? (s - F_Q_X) : s;
        return fe_t'(r);
    endfunction

    function automatic fe_t mod_reduce(input fe_t x);
        return (x >= F_Q) ? (x - F_Q) : x;
    endfunction

    function automatic fe_t mod_add(input fe_t a, input fe_t b);
        return mod_fold({1'b0, a} + {1'b0, b});
    endfunction

    function automatic fe_t one_minus(input fe_t x);
        return mod_fold({1'b0, ~x} + {1'b0, F_Q_P2_MI});
    endfunction

    // Mersenne fold: 2^61 == 1 mod F_Q, so hi*2^61 + lo reduces to hi + lo
    function automatic fe_t mod_mul(input fe_t a, input fe_t b);
        logic [2*F_NBITS-1:0] p;
        p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
        return mod_fold({1'b0, p[F_NBITS-1:0]} + {1'b0, p[2*F_NBITS-1:F_NBITS]});
    endfunction

endpackage

`default_nettype wire

// File: rtl/verifier_compute_io_pkg.sv
// Control-FSM state encoding for verifier_compute_io.
`default_nettype none

package verifier_compute_io_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_CHI     = 3'd2,
        S_ACCUM   = 3'd3,
        S_COMBINE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/verifier_compute_io_lane.sv
// One lane: expands its low-coordinate chi table from the given prefix, then
// multiply-accumulates chi_l * vals[l] over its contiguous slice.
`default_nettype none

module verifier_compute_io_lane
    import field_arith_defs::*;
#(
    parameter int nLowBits = 3,
    parameter int CNT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  expand_i,
    input  logic                  accum_i,
    input  logic [CNT_W-1:0]      step_i,
    input  logic [F_NBITS-1:0]    prefix_i,
    input  logic [F_NBITS-1:0]    tau_low_i [nLowBits],
    input  logic [F_NBITS-1:0]    vals_i [2**nLowBits],
    output logic [F_NBITS-1:0]    psum_o
);

    localparam int NPER = 2**nLowBits;

    fe_t chi_q [NPER];
    fe_t chi_d [NPER];
    fe_t acc_q;
    fe_t acc_d;
    fe_t t_w;
    fe_t tm_w;
    fe_t mac_chi_w;
    fe_t mac_val_w;

    // Expansion step s consumes coordinate tau_low[nLowBits-1-s]
    always_comb begin
        t_w = '0;
        for (int j = 0; j < nLowBits; j++)
            if (step_i == CNT_W'(nLowBits - 1 - j)) t_w = tau_low_i[j];
    end

    assign tm_w = one_minus(t_w);

    // Entry m comes from m/2; the first step seeds directly from the prefix
    for (genvar m = 0; m < NPER; m++) begin : g_chi
        fe_t src_w;
        assign src_w    = (step_i == '0) ? prefix_i : chi_q[m / 2];
        assign chi_d[m] = mod_mul(src_w, (m % 2 == 1) ? t_w : tm_w);
    end

    always_comb begin
        mac_chi_w = '0;
        mac_val_w = '0;
        for (int l = 0; l < NPER; l++) begin
            if (step_i == CNT_W'(l)) begin
                mac_chi_w = chi_q[l];
                mac_val_w = vals_i[l];
            end
        end
        acc_d = mod_add(acc_q, mod_mul(mac_chi_w, mac_val_w));
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int m = 0; m < NPER; m++) chi_q[m] <= '0;
            acc_q <= '0;
        end else begin
            if (expand_i) chi_q <= chi_d;
            if (expand_i && step_i == '0) acc_q <= '0;
            else if (accum_i)             acc_q <= acc_d;
        end
    end

    assign psum_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/verifier_compute_io.sv
// Multilinear-extension evaluator over GF(F_Q) split across 2^nParBits lanes.
// Optional: VERIFIER_COMPUTE_IO_REDUCE_EN reduces captured inputs mod F_Q.
`default_nettype none

module verifier_compute_io
    import field_arith_defs::*;
    import verifier_compute_io_pkg::*;
#(
    parameter int nValBits = 4,
    parameter int nParBits = 1
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  en,
    input  logic [F_NBITS-1:0]    tau [nValBits],
    input  logic [F_NBITS-1:0]    vals_in [2**nValBits],
    output logic [F_NBITS-1:0]    mlext_out,
    output logic                  ready
);

    localparam int NVAL  = 2**nValBits;
    localparam int NPAR  = 2**nParBits;
    localparam int NLOW  = nValBits - nParBits;
    localparam int NPER  = 2**NLOW;
    localparam int CNT_W = $clog2(NVAL) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lane_step_w;
    logic             capture_w, prefix_step_w, expand_w, accum_w;
    logic             sum_load_w, out_load_w;

    fe_t tau_q  [nValBits];
    fe_t vals_q [NVAL];
    fe_t lane_psum_w [NPAR];
    fe_t hi_t_w, hi_tm_w, total_w;
    fe_t sum_q, mlext_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lane_step_w   = cnt_q;
        capture_w     = 1'b0;
        prefix_step_w = 1'b0;
        expand_w      = 1'b0;
        accum_w       = 1'b0;
        sum_load_w    = 1'b0;
        out_load_w    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    capture_w = 1'b1;
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                cnt_d   = '0;
                state_d = S_CHI;
            end
            // High coordinates build lane prefixes, low ones expand inside lanes
            S_CHI: begin
                if (cnt_q < CNT_W'(nParBits)) begin
                    prefix_step_w = 1'b1;
                end else begin
                    expand_w    = 1'b1;
                    lane_step_w = cnt_q - CNT_W'(nParBits);
                end
                if (cnt_q == CNT_W'(nValBits - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACCUM: begin
                accum_w = 1'b1;
                if (cnt_q == CNT_W'(NPER - 1)) begin
                    cnt_d   = '0;
                    state_d = S_COMBINE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMBINE: begin
                sum_load_w = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                out_load_w = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            mlext_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (sum_load_w) sum_q   <= total_w;
            if (out_load_w) mlext_q <= sum_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int j = 0; j < nValBits; j++) tau_q[j]  <= '0;
            for (int i = 0; i < NVAL; i++)     vals_q[i] <= '0;
        end else if (capture_w) begin
            tau_q  <= tau;
            vals_q <= vals_in;
        end
`ifdef VERIFIER_COMPUTE_IO_REDUCE_EN
        else if (state_q == S_CAPTURE) begin
            for (int j = 0; j < nValBits; j++) tau_q[j]  <= mod_reduce(tau_q[j]);
            for (int i = 0; i < NVAL; i++)     vals_q[i] <= mod_reduce(vals_q[i]);
        end
`endif
    end

    always_comb begin
        hi_t_w = '0;
        for (int k = 0; k < nParBits; k++)
            if (cnt_q == CNT_W'(k)) hi_t_w = tau_q[nValBits - 1 - k];
    end

    assign hi_tm_w = one_minus(hi_t_w);

    for (genvar g = 0; g < NPAR; g++) begin : g_lane
        fe_t  prefix_q, prefix_d;
        logic hb_w;
        fe_t  tau_low_w [NLOW];
        fe_t  vals_w [NPER];

        // Lane index bit matching the high coordinate handled this cycle
        always_comb begin
            hb_w = 1'b0;
            for (int k = 0; k < nParBits; k++)
                if (cnt_q == CNT_W'(k)) hb_w = ((g >> (nParBits - 1 - k)) % 2) == 1;
            prefix_d = mod_mul(prefix_q, hb_w ? hi_t_w : hi_tm_w);
        end

        always_ff @(posedge clk) begin
            if (!rstb)                   prefix_q <= '0;
            else if (state_q == S_CAPTURE) prefix_q <= fe_t'(1);
            else if (prefix_step_w)      prefix_q <= prefix_d;
        end

        for (genvar j = 0; j < NLOW; j++) begin : g_tau
            assign tau_low_w[j] = tau_q[j];
        end
        for (genvar l = 0; l < NPER; l++) begin : g_val
            assign vals_w[l] = vals_q[g * NPER + l];
        end

        verifier_compute_io_lane #(
            .nLowBits (NLOW),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rstb      (rstb),
            .expand_i  (expand_w),
            .accum_i   (accum_w),
            .step_i    (lane_step_w),
            .prefix_i  (prefix_q),
            .tau_low_i (tau_low_w),
            .vals_i    (vals_w),
            .psum_o    (lane_psum_w[g])
        );
    end

    always_comb begin
        total_w = '0;
        for (int g = 0; g < NPAR; g++) total_w = mod_add(total_w, lane_psum_w[g]);
    end

    assign mlext_out = mlext_q;
    assign ready     = (state_q == S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_verifier_compute_io.sv
// Self-checking bench for verifier_compute_io against a direct chi/dot-product model.
`default_nettype none

module tb_verifier_compute_io;
    import field_arith_defs::*;

    localparam int NV    = 4;
    localparam int NP    = 1;
    localparam int NVALS = 16;
    localparam logic [127:0] QM = 128'h1FFF_FFFF_FFFF_FFFF;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    logic en   = 1'b0;
    fe_t  tau [NV];
    fe_t  vals_in [NVALS];
    fe_t  mlext_out;
    logic ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    verifier_compute_io #(
        .nValBits (NV),
        .nParBits (NP)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .en        (en),
        .tau       (tau),
        .vals_in   (vals_in),
        .mlext_out (mlext_out),
        .ready     (ready)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] m_mul(input logic [127:0] a, input logic [127:0] b);
        return (a * b) % QM;
    endfunction

    // Direct sum over i of prod_j (bit j of i ? tau[j] : 1-tau[j]) * vals[i]
    function automatic logic [63:0] model_mlext(input fe_t t [NV], input fe_t v [NVALS]);
        logic [127:0] acc;
        logic [127:0] chi;
        acc = '0;
        for (int i = 0; i < NVALS; i++) begin
            chi = 128'd1;
            for (int j = 0; j < NV; j++)
                chi = ((i >> j) & 1) ? m_mul(chi, 128'(t[j]))
                                     : m_mul(chi, (QM + 128'd1 - 128'(t[j])) % QM);
            acc = (acc + m_mul(chi, 128'(v[i]))) % QM;
        end
        return acc[63:0];
    endfunction

    function automatic fe_t rand_fe();
        logic [127:0] r;
        case ($urandom_range(0, 9))
            0:       r = 128'd0;
            1:       r = QM - 128'd1;
            default: r = {64'd0, $urandom(), $urandom()} % QM;
        endcase
        return r[F_NBITS-1:0];
    endfunction

    task automatic randomize_inputs();
        for (int j = 0; j < NV; j++)    tau[j]     = rand_fe();
        for (int i = 0; i < NVALS; i++) vals_in[i] = rand_fe();
    endtask

    task automatic start_op(input int hold);
        en = 1'b1;
        repeat (hold) @(negedge clk);
        en = 1'b0;
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp);
        int k;
        k = 0;
        while (!ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_value({tag, "_ready"}, 64'(ready), 64'd1);
        check_value({tag, "_result"}, 64'(mlext_out), exp);
    endtask

    task automatic run_op(input string tag, input logic [63:0] exp);
        start_op(1);
        check_value({tag, "_busy"}, 64'(ready), 64'd0);
        finish_op(tag, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp;
        for (int j = 0; j < NV; j++)    tau[j]     = '0;
        for (int i = 0; i < NVALS; i++) vals_in[i] = '0;

        rstb = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_ready", 64'(ready), 64'd1);
        check_value("rst_mlext", 64'(mlext_out), 64'd0);
        rstb = 1'b1;
        repeat (5) @(negedge clk);
        check_value("idle_ready", 64'(ready), 64'd1);

        for (int i = 0; i < NVALS; i++) vals_in[i] = fe_t'(i + 5);
        for (int j = 0; j < NV; j++)    tau[j]     = '0;
        run_op("tau_zero", 64'd5);

        for (int j = 0; j < NV; j++) tau[j] = fe_t'(1);
        run_op("tau_one", 64'd20);

        for (int j = 0; j < NV; j++) tau[j] = '0;
        tau[0] = fe_t'(1);
        run_op("tau_bit0", 64'd6);

        for (int i = 0; i < NVALS; i++) vals_in[i] = '0;
        vals_in[0] = fe_t'(3);
        vals_in[1] = fe_t'(7);
        tau[0]     = fe_t'(2);
        run_op("tau_two", 64'd11);

        for (int i = 0; i < NVALS; i++) vals_in[i] = fe_t'(1);
        for (int j = 0; j < NV; j++)    tau[j]     = rand_fe();
        run_op("vals_ones", 64'd1);
        repeat (3) @(negedge clk);
        check_value("hold_mlext", 64'(mlext_out), 64'd1);

        for (int i = 0; i < NVALS; i++) vals_in[i] = fe_t'(QM - 128'd1);
        for (int j = 0; j < NV; j++)    tau[j]     = rand_fe();
        run_op("vals_qm1", model_mlext(tau, vals_in));

        // Back-to-back: new start at the first idle sample after each completion
        for (int n = 0; n < 8; n++) begin
            randomize_inputs();
            exp = model_mlext(tau, vals_in);
            start_op((n == 0) ? 3 : 1);
            check_value($sformatf("b2b%0d_busy", n), 64'(ready), 64'd0);
            randomize_inputs();
            finish_op($sformatf("b2b%0d", n), exp);
        end

        randomize_inputs();
        exp = model_mlext(tau, vals_in);
        start_op(1);
        repeat (4) @(negedge clk);
        randomize_inputs();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check_value("ign_en_busy", 64'(ready), 64'd0);
        finish_op("ign_en", exp);

        randomize_inputs();
        start_op(1);
        repeat (5) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        check_value("abort_ready", 64'(ready), 64'd1);
        check_value("abort_mlext", 64'(mlext_out), 64'd0);
        repeat (20) @(negedge clk);
        check_value("abort_quiet_ready", 64'(ready), 64'd1);
        check_value("abort_quiet_mlext", 64'(mlext_out), 64'd0);

        randomize_inputs();
        run_op("post_abort", model_mlext(tau, vals_in));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/verifier_compute_io.md
Name: verifier_compute_io

Overview:
- Verifier-side evaluation of the multilinear extension of a 2^nValBits-entry vector at a point tau, over the prime field GF(F_Q).
- Result: mlext_out = sum over i of chi_i(tau) * vals_in[i] mod F_Q.
  - chi_i(tau) = product over j of (bit j of i ? tau[j] : 1 - tau[j]).
  - Bit 0 of i pairs with tau[0].
- Used for input/output checking in the verifier.
- Work is split across 2^nParBits parallel lanes.

Parameters:
- nValBits, default 4: number of tau coordinates; nValues = 2^nValBits.
- nParBits, default 1: log2 of lane count, nParallel = 2^nParBits. Constraint: nParBits < nValBits. Each lane handles nValuesPer = 2^(nValBits-nParBits) contiguous indices.

Ports:
- clk, input, 1: the only clock; all logic on posedge.
- rstb, input, 1: reset; synchronous, active-low.
- en, input, 1: start request.
- tau, input, array [nValBits] of F_NBITS: evaluation point.
- vals_in, input, array [nValues] of F_NBITS: vector values.
- mlext_out, output, F_NBITS: result, canonical (< F_Q).
- ready, output, 1: high when idle and mlext_out is valid.

Behaviour:
- Reset (rstb=0 at posedge):
  - ready=1, mlext_out=0, all lanes idle.
  - Reset mid-computation aborts the operation; no result is produced.
- Start:
  - en=1 at a posedge while ready=1 captures tau and vals_in into internal registers.
  - ready drops to 0 the same edge.
  - Inputs may change freely after capture.
- en while ready=0 is ignored; a held en does not restart. After completion, a still-high en starts a new operation on the next edge.
- Operation:
  - Compute the chi table by iterative doubling from the top coordinate down:
    - chi = {1 - tau[n-1], tau[n-1]};
    - for coordinate tau[n-1-k], entry c at index m becomes index 2m (c * (1 - t)) and index 2m+1 (c * t).
  - Lane g owns indices g*nValuesPer .. (g+1)*nValuesPer - 1 and accumulates chi_i * vals_in[i] into a partial sum.
  - Partial sums are added mod F_Q to form the result.
- All products and sums are reduced mod F_Q. Arithmetic width is F_NBITS.
- 1 - x is computed as (~x + F_Q_P2_MI) mod F_Q, and is valid for x < F_Q.
- Inputs must be canonical (< F_Q) unless VERIFIER_COMPUTE_IO_REDUCE_EN is defined.
- Completion:
  - mlext_out is updated and ready returns to 1 on the same edge.
  - mlext_out holds until the next completion or reset.
- Latency:
  - Fixed for a given parameter set and data-independent.
  - Must not exceed (nValues/nParallel + nValBits + 4) multiplier-latency units.
  - The bench relies only on the ready handshake.
- Boundary cases:
  - tau all 0 gives vals_in[0].
  - tau all 1 gives vals_in[nValues-1].
  - A value equal to 0 or F_Q-1 must reduce correctly; there is no overflow beyond F_NBITS after each reduction.

Optional Feature:
- VERIFIER_COMPUTE_IO_REDUCE_EN:
  - Defined: each captured tau and vals_in word is reduced mod F_Q at capture, so arbitrary F_NBITS inputs are accepted. Adds at most one cycle of latency.
  - Undefined: no input reduction; non-canonical inputs give an unspecified result.

Decomposition:
- Shared package (field_arith_defs), consumed, not redefined:
  - F_NBITS, F_Q, F_Q_P2_MI;
  - field element typedef;
  - one_minus, mod-add and mod-mul helpers.
- Natural sub-module: verifier_compute_io_lane.
  - Contains the per-lane chi expansion for its low coordinates and the multiply-accumulate.
  - Is given its lane's high-coordinate chi prefix.
- The top level holds capture registers, the control FSM (IDLE, CAPTURE, CHI, ACCUM, COMBINE, DONE) and the final lane-sum tree.

Test Plan:
- Reset, then idle: ready=1, mlext_out=0; en held low keeps ready=1.
- tau all 0, vals_in[i]=i+5, en one cycle: ready falls, then returns with mlext_out=5.
- tau all 1, same vals: mlext_out=20. Then tau[0]=1 with others 0: mlext_out=6.
- tau[0]=2 with others 0, vals_in[0]=3, vals_in[1]=7: mlext_out = 2*7 - 3 = 11.
- vals_in all 1 with arbitrary canonical tau: mlext_out=1.
- Random sequence:
  - 8 back-to-back operations with random canonical tau/vals, a new en the cycle after each ready rise, en held 3 cycles on the first: every result matches a software chi/dot-product model.
  - en pulsed mid-operation is ignored.
  - rstb low mid-operation gives ready=1 and mlext_out=0.
